// File: rtl/cpu_controller_pkg.sv
// Shared definitions for the cpu_controller slice: state encoding, instruction
// field constants, ALU operation codes and writeback-source codes.
package cpu_controller_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_EXEC      = 3'd5,
        S_WRITE_REG = 3'd6,
        S_ERR       = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        K_MOV_IMM = 3'd0,
        K_MOV_REG = 3'd1,
        K_ADD     = 3'd2,
        K_CMP     = 3'd3,
        K_AND     = 3'd4,
        K_MVN     = 3'd5,
        K_ILLEGAL = 3'd7
    } kind_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_AND  = 2'b10;
    localparam logic [1:0] ALUOP_NOTB = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/cpu_controller_decode.sv
// Purely combinational instruction decoder: splits IR into its fields,
// sign-extends the immediates and classifies the instruction.
module ctrl_decode
    import cpu_controller_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [2:0]  rn_o,
    output logic [2:0]  rd_o,
    output logic [2:0]  rm_o,
    output logic [1:0]  sh_o,
    output logic [1:0]  op_o,
    output logic [15:0] sximm5_o,
    output logic [15:0] sximm8_o,
    output logic        legal_o,
    output kind_t       kind_o
);

    logic [2:0] opcode;

    assign opcode   = ir_i[15:13];
    assign op_o     = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign sh_o     = ir_i[4:3];
    assign rm_o     = ir_i[2:0];
    assign sximm5_o = sext5(ir_i[4:0]);
    assign sximm8_o = sext8(ir_i[7:0]);

    always_comb begin
        kind_o = K_ILLEGAL;
        if (opcode == OPC_MOV) begin
            case (op_o)
                OP_MOV_IMM: kind_o = K_MOV_IMM;
                OP_MOV_REG: kind_o = K_MOV_REG;
                default:    kind_o = K_ILLEGAL;
            endcase
        end else if (opcode == OPC_ALU) begin
            case (op_o)
                OP_ADD:  kind_o = K_ADD;
                OP_CMP:  kind_o = K_CMP;
                OP_AND:  kind_o = K_AND;
                default: kind_o = K_MVN;
            endcase
        end
    end

    assign legal_o = (kind_o != K_ILLEGAL);

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle datapath controller. Build with CTRL_ILLEGAL_TRAP_EN defined to
// trap illegal instructions in ERR (err=1 until reset); otherwise they are skipped.
module cpu_controller
    import cpu_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        err
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh, op;
    logic        legal;
    kind_t       kind;

    ctrl_decode u_decode (
        .ir_i     (ir_q),
        .rn_o     (rn),
        .rd_o     (rd),
        .rm_o     (rm),
        .sh_o     (sh),
        .op_o     (op),
        .sximm5_o (sximm5),
        .sximm8_o (sximm8),
        .legal_o  (legal),
        .kind_o   (kind)
    );

    assign shift = sh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        w        = 1'b0;
        err      = 1'b0;
        ALUop    = ALUOP_ADD;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = VSEL_C;

        case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    ir_d    = in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = S_ERR;
`else
                    state_d = S_WAIT;
`endif
                end else begin
                    case (kind)
                        K_MOV_IMM:      state_d = S_WRITE_IMM;
                        K_MOV_REG,
                        K_MVN:          state_d = S_GET_B;
                        default:        state_d = S_GET_A;
                    endcase
                end
            end
            S_WRITE_IMM: begin
                write    = 1'b1;
                writenum = rn;
                vsel     = VSEL_IMM8;
                state_d  = S_WAIT;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = S_GET_B;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // A register move passes B through the adder with A forced to zero.
                loadc   = 1'b1;
                asel    = (kind == K_MOV_REG);
                ALUop   = (kind == K_MOV_REG) ? ALUOP_ADD : op;
                loads   = (kind == K_CMP);
                state_d = (kind == K_CMP) ? S_WAIT : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                write    = 1'b1;
                writenum = rd;
                vsel     = VSEL_C;
                state_d  = S_WAIT;
            end
            S_ERR: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                err = 1'b1;
`endif
                state_d = S_ERR;
            end
            default: state_d = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed instructions followed by
// randomized instruction streams compared cycle by cycle with a step-list model.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [15:0] in_v;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, err;
    logic [1:0]  ALUop, shift, vsel;
    logic [2:0]  readnum, writenum;
    logic [15:0] sximm5, sximm8;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       w;
        logic       err;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] aluop;
        logic [1:0] vsel;
        logic [2:0] readnum;
        logic [2:0] writenum;
    } obs_t;

    obs_t exp_q[$];

    cpu_controller dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .in       (in_v),
        .w        (w),
        .ALUop    (ALUop),
        .shift    (shift),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .sximm5   (sximm5),
        .sximm8   (sximm8),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t o;
        o.w = w; o.err = err; o.write = write; o.loada = loada; o.loadb = loadb;
        o.loadc = loadc; o.loads = loads; o.asel = asel; o.bsel = bsel;
        o.aluop = ALUop; o.vsel = vsel; o.readnum = readnum; o.writenum = writenum;
        return o;
    endfunction

    function automatic obs_t idle_step();
        obs_t st = '0;
        st.w = 1'b1;
        return st;
    endfunction

    // Expected per-cycle behaviour after an accepted start, one entry per clock
    // edge; the last entry is the WAIT cycle where w returns high.
    function automatic bit build(input logic [15:0] ir);
        int opc = int'(ir[15:13]);
        int op  = int'(ir[12:11]);
        obs_t st;
        exp_q.delete();
        exp_q.push_back('0);
        if (opc == 6 && op == 2) begin
            st = '0; st.write = 1; st.writenum = ir[10:8]; st.vsel = 2'd2; exp_q.push_back(st);
        end else if (opc == 6 && op == 0) begin
            st = '0; st.loadb = 1; st.readnum = ir[2:0]; exp_q.push_back(st);
            st = '0; st.loadc = 1; st.asel = 1; st.aluop = 2'd0; exp_q.push_back(st);
            st = '0; st.write = 1; st.writenum = ir[7:5]; st.vsel = 2'd0; exp_q.push_back(st);
        end else if (opc == 5) begin
            if (op != 3) begin
                st = '0; st.loada = 1; st.readnum = ir[10:8]; exp_q.push_back(st);
            end
            st = '0; st.loadb = 1; st.readnum = ir[2:0]; exp_q.push_back(st);
            st = '0; st.loadc = 1; st.aluop = op[1:0]; st.loads = (op == 1); exp_q.push_back(st);
            if (op != 1) begin
                st = '0; st.write = 1; st.writenum = ir[7:5]; st.vsel = 2'd0; exp_q.push_back(st);
            end
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            for (int k = 0; k < 3; k++) begin
                st = '0; st.err = 1; exp_q.push_back(st);
            end
            return 1'b1;
`endif
        end
        exp_q.push_back(idle_step());
        return 1'b0;
    endfunction

    task automatic check_step(input obs_t e, input string tag);
        obs_t o = sample();
        obs_t m = '0;
        m.w = 1; m.err = 1; m.write = 1; m.loada = 1; m.loadb = 1; m.loadc = 1; m.loads = 1;
        if (e.loada || e.loadb) m.readnum = '1;
        if (e.write) begin m.writenum = '1; m.vsel = '1; end
        if (e.loadc) begin m.aluop = '1; m.asel = 1; m.bsel = 1; end
        n_cmp++;
        assert (((o ^ e) & m) === obs_t'('0))
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h care=%h", tag, o, e, m);
        end
    endtask

    task automatic check_imm(input logic [15:0] ir, input string tag);
        int v5 = int'(ir[4:0]);
        int v8 = int'(ir[7:0]);
        logic [33:0] got, want;
        if (v5 >= 16)  v5 -= 32;
        if (v8 >= 128) v8 -= 256;
        want = {ir[4:3], v5[15:0], v8[15:0]};
        got  = {shift, sximm5, sximm8};
        n_cmp++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s imm observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Called on a negedge; returns on the negedge of the final expected step.
    task automatic run_instr(input logic [15:0] ir, output bit trapped);
        trapped = build(ir);
        s = 1'b1;
        in_v = ir;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            s = 1'b0;
            in_v = 16'($urandom);
            check_step(exp_q[i], $sformatf("ir=%h step%0d", ir, i));
            if (i == 0 || i == exp_q.size() - 1)
                check_imm(ir, $sformatf("ir=%h step%0d", ir, i));
        end
        $display("instr %h: %0d cycles checked%s", ir, exp_q.size(), trapped ? " (trapped)" : "");
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b0;
        #1;
        check_step(idle_step(), {tag, " in reset"});
        check_imm(16'h0000, {tag, " in reset"});
        @(negedge clk);
        check_step(idle_step(), {tag, " held reset"});
        reset = 1'b1;
        $display("reset %s applied", tag);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_v = 16'($urandom);
            check_step(idle_step(), "idle wait");
        end
    endtask

    initial begin : stim
        bit          trapped;
        logic [15:0] ir;
        int          r;
        reset = 1'b1;
        s     = 1'b0;
        in_v  = 16'h0;
        @(negedge clk);
        apply_reset("power-on");
        idle(2);

        run_instr(16'hD007, trapped);
        run_instr(16'hA148, trapped);
        run_instr(16'hA900, trapped);
        run_instr(16'hB861, trapped);
        run_instr(16'hB4A9, trapped);
        run_instr(16'hC05A, trapped);
        run_instr(16'hD3F0, trapped);

        run_instr(16'hE000, trapped);
        if (trapped) apply_reset("after trap");
        idle(1);

        // Abort an ADD while in GET_B; no writeback may follow.
        void'(build(16'hA148));
        s = 1'b1;
        in_v = 16'hA148;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s = 1'b0;
            check_step(exp_q[i], $sformatf("abort add step%0d", i));
        end
        apply_reset("mid-instruction");
        idle(4);
        run_instr(16'hD1FF, trapped);

        for (int n = 0; n < 80; n++) begin
            r  = $urandom_range(0, 9);
            ir = 16'($urandom);
            if (r < 4)      ir[15:13] = 3'b101;
            else if (r < 8) ir[15:13] = 3'b110;
            run_instr(ir, trapped);
            if (trapped) apply_reset("random trap");
            idle($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
